// File: rtl/verdict_collector_if.sv
// Verdict drain handshake between the collector (master) and the host-side logger (slave).
interface verdict_collector_if #(
    parameter int DW = 64,
    parameter int TW = 32
) ();
    logic          v_valid;
    logic          v_ready;
    logic          v_tag;
    logic [DW-1:0] v_data;
    logic [TW-1:0] v_ts;

    modport master (
        output v_valid,
        output v_tag,
        output v_data,
        output v_ts,
        input  v_ready
    );

    modport slave (
        input  v_valid,
        input  v_tag,
        input  v_data,
        input  v_ts,
        output v_ready
    );
endinterface

// File: rtl/verdict_collector.sv
// Timestamps monitor stream activations, buffers them in a FIFO and drains one verdict
// word per handshake; dual-stream entries are emitted as an A word followed by a B word.
module verdict_collector #(
    parameter int DW    = 64,
    parameter int TW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DW-1:0]        out_a,
    input  logic                 aktv_a,
    input  logic [DW-1:0]        out_b,
    input  logic                 aktv_b,
    verdict_collector_if.master  vif,
    output logic                 overflow,
    output logic [CW-1:0]        drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [TW-1:0] ts;
        logic          ma;
        logic          mb;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_ts;
    state_t        r_state;
    logic          r_head_mb;
    logic          r_valid;
    logic          r_tag;
    logic [DW-1:0] r_data;
    logic [TW-1:0] r_v_ts;
    logic          r_overflow;
    logic [CW-1:0] r_drop_count;

    entry_t        w_in;
    entry_t        w_head;
    entry_t        w_nxt;
    logic          w_nxt_avail;
    logic          w_push;
    logic          w_push_ok;
    logic          w_hs;
    logic          w_pop;
    logic          w_reload;
    logic          w_to_b;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_cnt_after_pop;
    state_t        w_ld_state;
    logic          w_ld_tag;
    logic [DW-1:0] w_ld_data;

    // Push/pop decisions and selection of the entry to present after this edge.
    always_comb begin
        w_in.ts = r_ts;
        w_in.ma = aktv_a;
        w_in.mb = aktv_b;
        w_in.a  = out_a;
        w_in.b  = out_b;
        w_head  = r_mem[r_rd_ptr];
        w_push  = en & (aktv_a | aktv_b);
        w_hs    = r_valid & vif.v_ready;
        case (r_state)
            IDLE: begin
                w_pop    = 1'b0;
                w_reload = 1'b1;
                w_to_b   = 1'b0;
            end
            SEND_A: begin
                w_pop    = w_hs & ~r_head_mb;
                w_reload = w_hs & ~r_head_mb;
                w_to_b   = w_hs & r_head_mb;
            end
            SEND_B: begin
                w_pop    = w_hs;
                w_reload = w_hs;
                w_to_b   = 1'b0;
            end
            default: begin
                w_pop    = 1'b0;
                w_reload = 1'b1;
                w_to_b   = 1'b0;
            end
        endcase
        w_push_ok       = w_push & ((r_count != L_FULL) | w_pop);
        w_rd_ptr_nxt    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
        w_cnt_after_pop = w_pop ? (r_count - (AW+1)'(1)) : r_count;
        // With nothing left behind the popped head, the entry being written now is bypassed out.
        if (w_cnt_after_pop != {(AW+1){1'b0}}) begin
            w_nxt       = r_mem[w_rd_ptr_nxt];
            w_nxt_avail = 1'b1;
        end else if (w_push_ok) begin
            w_nxt       = w_in;
            w_nxt_avail = 1'b1;
        end else begin
            w_nxt       = w_in;
            w_nxt_avail = 1'b0;
        end
        w_ld_state = w_nxt.ma ? SEND_A : SEND_B;
        w_ld_tag   = ~w_nxt.ma;
        w_ld_data  = w_nxt.ma ? w_nxt.a : w_nxt.b;
    end

    // Entry storage; stale contents are never read because count gates every access.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // Timestamp counter, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts     <= {TW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (en) begin
                r_ts <= r_ts + TW'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= {CW{1'b0}};
        end else if (w_push & ~w_push_ok) begin
            r_overflow <= 1'b1;
            if (r_drop_count != {CW{1'b1}}) begin
                r_drop_count <= r_drop_count + CW'(1);
            end
        end
    end

    // Drain FSM with registered handshake outputs; they only move on a handshake or from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_head_mb <= 1'b0;
            r_valid   <= 1'b0;
            r_tag     <= 1'b0;
            r_data    <= {DW{1'b0}};
            r_v_ts    <= {TW{1'b0}};
        end else if (w_to_b) begin
            r_state <= SEND_B;
            r_tag   <= 1'b1;
            r_data  <= w_head.b;
        end else if (w_reload) begin
            if (w_nxt_avail) begin
                r_state   <= w_ld_state;
                r_head_mb <= w_nxt.mb;
                r_valid   <= 1'b1;
                r_tag     <= w_ld_tag;
                r_data    <= w_ld_data;
                r_v_ts    <= w_nxt.ts;
            end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
            end
        end
    end

    assign vif.v_valid = r_valid;
    assign vif.v_tag   = r_tag;
    assign vif.v_data  = r_data;
    assign vif.v_ts    = r_v_ts;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;
endmodule
